// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath: sequences fetch, decode,
// execute, memory and writeback, and drives the datapath steering signals.
module multicycle_control (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        MemRd,
  output logic        MemWr,
  output logic        IorD,
  output logic        IRWr,
  output logic        PCWr,
  output logic [1:0]  PCSrc,
  output logic        RegWr,
  output logic        RegDst,
  output logic        MemToReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUCntrl,
  output logic        ZeroExt,
  output logic        Illegal,
  output logic [3:0]  State
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] EXEC   = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWR  = 4'd4;
  localparam logic [3:0] WB     = 4'd5;
  localparam logic [3:0] BRANCH = 4'd6;
  localparam logic [3:0] JUMP   = 4'd7;
  localparam logic [3:0] HALT   = 4'd8;

  logic [3:0] state_q, state_d;
  logic [5:0] op, funct;
  logic       is_r, i_add, i_sub, i_slt, i_jr, i_lw, i_sw, i_bne, i_xori, i_j;
  logic       i_alu;
  logic       unused_instr;

  assign op     = Instr[31:26];
  assign funct  = Instr[5:0];
  assign is_r   = (op == 6'b000000);
  assign i_add  = is_r && (funct == 6'b100000);
  assign i_sub  = is_r && (funct == 6'b100010);
  assign i_slt  = is_r && (funct == 6'b101010);
  assign i_jr   = is_r && (funct == 6'b001000);
  assign i_lw   = (op == 6'b100011);
  assign i_sw   = (op == 6'b101011);
  assign i_bne  = (op == 6'b000101);
  assign i_xori = (op == 6'b001110);
  assign i_j    = (op == 6'b000010);
  assign i_alu  = i_add || i_sub || i_slt || i_lw || i_sw || i_xori;

  // Register/immediate fields are consumed by the datapath, not by control.
  assign unused_instr = ^Instr[25:6];

  assign State = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // Memory handshake: a request (MemRd or MemWr) is held every cycle of the
  // access state; the access completes in the cycle MemReady is sampled high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (MemReady) state_d = DECODE;
      DECODE: begin
        if (i_alu)              state_d = EXEC;
        else if (i_bne)         state_d = BRANCH;
        else if (i_j || i_jr)   state_d = JUMP;
        else                    state_d = HALT;
      end
      EXEC: begin
        if (i_lw)      state_d = MEMRD;
        else if (i_sw) state_d = MEMWR;
        else           state_d = WB;
      end
      MEMRD:  if (MemReady) state_d = WB;
      MEMWR:  if (MemReady) state_d = FETCH;
      WB:     state_d = FETCH;
      BRANCH: state_d = FETCH;
      JUMP:   state_d = FETCH;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    IRWr     = 1'b0;
    PCWr     = 1'b0;
    PCSrc    = 2'b00;
    RegWr    = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUCntrl = 2'b00;
    ZeroExt  = 1'b0;
    Illegal  = 1'b0;
    case (state_q)
      FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        // Reset parks the FSM in FETCH; keep the load strobes quiet meanwhile.
        IRWr    = MemReady && reset_n;
        PCWr    = MemReady && reset_n;
      end
      DECODE: ALUSrcB = 2'b11;
      EXEC: begin
        ALUSrcA = 1'b1;
        if (is_r) begin
          ALUSrcB  = 2'b00;
          ALUCntrl = i_sub ? 2'b10 : (i_slt ? 2'b11 : 2'b00);
        end else if (i_xori) begin
          ALUSrcB  = 2'b10;
          ALUCntrl = 2'b01;
          ZeroExt  = 1'b1;
        end else begin
          ALUSrcB  = 2'b10;
        end
      end
      MEMRD: begin
        MemRd = 1'b1;
        IorD  = 1'b1;
      end
      MEMWR: begin
        MemWr = 1'b1;
        IorD  = 1'b1;
      end
      WB: begin
        RegWr    = 1'b1;
        RegDst   = is_r;
        MemToReg = i_lw;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCntrl = 2'b10;
        PCSrc    = 2'b01;
        PCWr     = !Zero;
      end
      JUMP: begin
        PCWr  = 1'b1;
        PCSrc = i_jr ? 2'b11 : 2'b10;
      end
      HALT: Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected State and control
// vectors are queued by hand and compared against the DUT each cycle.
module tb_multicycle_control;

  logic        clk;
  logic        reset_n;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        MemRd, MemWr, IorD, IRWr, PCWr, RegWr, RegDst, MemToReg;
  logic        ALUSrcA, ZeroExt, Illegal;
  logic [1:0]  PCSrc, ALUSrcB, ALUCntrl;
  logic [3:0]  State;
  logic [16:0] ctl_obs;

  int checks   = 0;
  int failures = 0;

  logic [20:0] exp_q[$];
  logic [1:0]  stim_q[$];

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
    .MemRd(MemRd), .MemWr(MemWr), .IorD(IorD), .IRWr(IRWr), .PCWr(PCWr),
    .PCSrc(PCSrc), .RegWr(RegWr), .RegDst(RegDst), .MemToReg(MemToReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCntrl(ALUCntrl), .ZeroExt(ZeroExt),
    .Illegal(Illegal), .State(State)
  );

  assign ctl_obs = {MemRd, MemWr, IorD, IRWr, PCWr, PCSrc, RegWr, RegDst, MemToReg,
                    ALUSrcA, ALUSrcB, ALUCntrl, ZeroExt, Illegal};

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [16:0] ctl(input logic memrd, memwr, iord, irwr, pcwr,
                                      input logic [1:0] pcsrc,
                                      input logic regwr, regdst, memtoreg, srca,
                                      input logic [1:0] srcb, aluc,
                                      input logic zext, ill);
    return {memrd, memwr, iord, irwr, pcwr, pcsrc, regwr, regdst, memtoreg,
            srca, srcb, aluc, zext, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic [3:0] st, input logic [16:0] c, input logic mr, input logic z);
    exp_q.push_back({st, c});
    stim_q.push_back({mr, z});
  endtask

  task automatic run(input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0) begin
      logic [20:0] e;
      logic [1:0]  s;
      e = exp_q.pop_front();
      s = stim_q.pop_front();
      MemReady = s[1];
      Zero     = s[0];
      #1;
      check_eq($sformatf("%s_c%0d_state", tag, n), {28'd0, State}, {28'd0, e[20:17]});
      check_eq($sformatf("%s_c%0d_ctl", tag, n), {15'd0, ctl_obs}, {15'd0, e[16:0]});
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  logic [16:0] c_rst, c_fgo, c_dec, c_wbr;

  initial begin
    c_rst = ctl(1,0,0,0,0,2'd0,0,0,0,0,2'd1,2'd0,0,0);
    c_fgo = ctl(1,0,0,1,1,2'd0,0,0,0,0,2'd1,2'd0,0,0);
    c_dec = ctl(0,0,0,0,0,2'd0,0,0,0,0,2'd3,2'd0,0,0);
    c_wbr = ctl(0,0,0,0,0,2'd0,1,1,0,0,2'd0,2'd0,0,0);

    reset_n  = 1'b0;
    Instr    = 32'h0022_1820;
    Zero     = 1'b0;
    MemReady = 1'b0;
    #2 MemReady = 1'b1;
    #1;
    check_eq("rst_state", {28'd0, State}, 32'd0);
    check_eq("rst_ctl", {15'd0, ctl_obs}, {15'd0, c_rst});
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // ADD
    Instr = 32'h0022_1820;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd0,0,0), 1, 0);
    push(4'd5, c_wbr, 1, 0);
    run("add");

    // SUB
    Instr = 32'h0022_1822;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd2,0,0), 1, 0);
    push(4'd5, c_wbr, 1, 0);
    run("sub");

    // SLT
    Instr = 32'h0022_182A;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd3,0,0), 1, 0);
    push(4'd5, c_wbr, 1, 0);
    run("slt");

    // XORI
    Instr = 32'h3822_00FF;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd1,1,0), 1, 0);
    push(4'd5, ctl(0,0,0,0,0,2'd0,1,0,0,0,2'd0,2'd0,0,0), 1, 0);
    run("xori");

    // LW, memory stalls three cycles in MEMRD
    Instr = 32'h8C22_0004;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0,0), 1, 0);
    for (int i = 0; i < 3; i++) push(4'd3, ctl(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0), 0, 0);
    push(4'd3, ctl(1,0,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0), 1, 0);
    push(4'd5, ctl(0,0,0,0,0,2'd0,1,0,1,0,2'd0,2'd0,0,0), 1, 0);
    run("lw");

    // SW, fetch stalls one cycle first
    Instr = 32'hAC22_0004;
    push(4'd0, c_rst, 0, 0);
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0,0), 1, 0);
    push(4'd4, ctl(0,1,1,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,0), 1, 0);
    run("sw");

    // BNE taken / not taken
    Instr = 32'h1422_0003;
    push(4'd0, c_fgo, 1, 1);
    push(4'd1, c_dec, 1, 1);
    push(4'd6, ctl(0,0,0,0,0,2'd1,0,0,0,1,2'd0,2'd2,0,0), 1, 1);
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd6, ctl(0,0,0,0,1,2'd1,0,0,0,1,2'd0,2'd2,0,0), 1, 0);
    run("bne");

    // JR then J
    Instr = 32'h0020_0008;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd7, ctl(0,0,0,0,1,2'd3,0,0,0,0,2'd0,2'd0,0,0), 1, 0);
    run("jr");
    Instr = 32'h0800_0010;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd7, ctl(0,0,0,0,1,2'd2,0,0,0,0,2'd0,2'd0,0,0), 1, 0);
    run("j");

    // SW interrupted by reset in MEMWR
    Instr = 32'hAC22_0004;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd2,2'd0,0,0), 1, 0);
    run("swrst");
    MemReady = 1'b0;
    #1;
    check_eq("swrst_memwr_pre", {31'd0, MemWr}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("swrst_memwr_rst", {31'd0, MemWr}, 32'd0);
    check_eq("swrst_state_rst", {28'd0, State}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    Instr   = 32'h0022_1820;
    reset_n = 1'b1;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    push(4'd2, ctl(0,0,0,0,0,2'd0,0,0,0,1,2'd0,2'd0,0,0), 1, 0);
    push(4'd5, c_wbr, 1, 0);
    run("postrst_add");

    // Illegal opcode parks in HALT until reset
    Instr = 32'hFC00_0000;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    for (int i = 0; i < 10; i++) push(4'd8, ctl(0,0,0,0,0,2'd0,0,0,0,0,2'd0,2'd0,0,1), 1, 0);
    run("ill");
    reset_n = 1'b0;
    #1;
    check_eq("ill_rst_state", {28'd0, State}, 32'd0);
    check_eq("ill_rst_illegal", {31'd0, Illegal}, 32'd0);
    @(posedge clk); #1;
    Instr   = 32'h0022_1820;
    reset_n = 1'b1;
    push(4'd0, c_fgo, 1, 0);
    push(4'd1, c_dec, 1, 0);
    run("ill_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL update on the rising edge of clk.
REQ-002 clk  input  1  system clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 Instr  input  32  instruction register output; stable except in the cycle after IRWr.
REQ-005 Zero  input  1  ALU zero flag, combinational from the current ALU operation.
REQ-006 MemReady  input  1  shared memory completes the current access this cycle.
REQ-007 MemRd, MemWr, IorD  output  1 each  memory read request, memory write request, address select (0 = PC, 1 = ALUOut).
REQ-008 IRWr, PCWr  output  1 each  instruction register load, PC load.
REQ-009 PCSrc  output  2  PC source: 00 = ALU (PC+4), 01 = branch target, 10 = {PC[31:28],Instr[25:0],2'b00}, 11 = register Rs.
REQ-010 RegWr, RegDst, MemToReg  output  1 each  register write, destination select (1 = Rd, 0 = Rt), writeback source (1 = MDR).
REQ-011 ALUSrcA  output  1  0 = PC, 1 = register A; ALUSrcB output 2: 00 = B, 01 = constant 4, 10 = Imm16 extended, 11 = Imm16 extended <<2.
REQ-012 ALUCntrl  output  2  00 add, 01 xor, 10 sub, 11 slt; ZeroExt output 1: 1 = zero-extend Imm16.
REQ-013 Illegal  output  1  unsupported instruction decoded; State output 4: current state code, for debug.

Function
REQ-014 Supported instructions: R-type (opcode 000000) funct 100000 ADD, 100010 SUB, 101010 SLT, 001000 JR; opcodes 100011 LW, 101011 SW, 000101 BNE, 001110 XORI, 000010 J; all others are illegal.
REQ-015 State codes: FETCH=0, DECODE=1, EXEC=2, MEMRD=3, MEMWR=4, WB=5, BRANCH=6, JUMP=7, HALT=8; codes 9-15 unreachable and SHALL go to FETCH.
REQ-016 Outputs SHALL be Moore outputs: functions of State and Instr only, with no output dependent on MemReady except PCWr and IRWr in FETCH and PCWr in BRANCH, as specified below.
REQ-017 Outputs not listed as asserted in a state SHALL be 0.
REQ-018 FETCH: MemRd=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCntrl=00, PCSrc=00; while MemReady=0, remain in FETCH; when MemReady=1, IRWr=1 and PCWr=1 in the same cycle, and the next state is DECODE.
REQ-019 DECODE: ALUSrcA=0, ALUSrcB=11, ALUCntrl=00 (branch target precompute); next state is EXEC for ADD/SUB/SLT/LW/SW/XORI, BRANCH for BNE, JUMP for J/JR, and HALT otherwise.
REQ-020 EXEC: ALUSrcA=1; R-type uses ALUSrcB=00 with ALUCntrl from funct; LW/SW use ALUSrcB=10, ALUCntrl=00, ZeroExt=0; XORI uses ALUSrcB=10, ALUCntrl=01, ZeroExt=1; next state is MEMRD for LW, MEMWR for SW, WB otherwise.
REQ-021 MEMRD: MemRd=1, IorD=1; hold until MemReady=1, then go to WB.
REQ-022 MEMWR: MemWr=1, IorD=1; hold until MemReady=1, then go to FETCH; MemWr SHALL be asserted in every MEMWR cycle and in no other state.
REQ-023 WB: RegWr=1 for exactly one cycle; RegDst=1, MemToReg=0 for R-type; RegDst=0, MemToReg=0 for XORI; RegDst=0, MemToReg=1 for LW; next state is FETCH.
REQ-024 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCntrl=10, PCSrc=01, PCWr=(Zero==0); next state is FETCH.
REQ-025 JUMP: PCWr=1, PCSrc=10 for J and 11 for JR; next state is FETCH.
REQ-026 HALT: Illegal=1 and all other outputs are 0; the block SHALL remain in HALT until reset.
REQ-027 Cycle counts with MemReady constantly 1: ADD/SUB/SLT/XORI take 4 cycles, LW takes 5, SW takes 4, BNE/J/JR take 3.
REQ-028 RegWr and MemWr SHALL never both be 1 in the same cycle, and PCWr SHALL never be asserted in MEMRD, MEMWR, WB, or EXEC.

Reset
REQ-029 While reset_n=0, asynchronously, State SHALL be FETCH and every output SHALL be 0 except MemRd=1, ALUSrcB=01, and State=0.
REQ-030 If reset is asserted during MEMWR or WB, MemWr and RegWr SHALL deassert immediately, and no write SHALL be issued after reset is released.
REQ-031 After reset_n rises, the first fetch SHALL begin on the next rising edge of clk.

Verification
REQ-032 ADD (funct 100000), MemReady=1: State sequence 0,1,2,5,0; RegWr=1 only in cycle 4 with RegDst=1.
REQ-033 LW with MemReady held low for 3 cycles in MEMRD: State sequence 0,1,2,3,3,3,3,5,0; MemRd=1, IorD=1 throughout MEMRD.
REQ-034 BNE with Zero=1, then BNE with Zero=0: PCWr=0 in BRANCH for the first; PCWr=1 with PCSrc=01 for the second.
REQ-035 JR (funct 001000) then J (opcode 000010): PCSrc=11, then PCSrc=10, each with PCWr=1 in JUMP.
REQ-036 Opcode 111111: State reaches 8 after DECODE and Illegal=1; State stays at 8 for 10 cycles; after reset pulse, State=0 and Illegal=0.
REQ-037 SW with reset_n driven low mid-MEMWR: MemWr falls in the same cycle as reset; after release, State=0 and no MemWr is seen until the next SW.
